// File: rtl/y_buf_argmax_sink.sv
// rtl/y_buf_argmax_sink.sv - y_buf write capture, per-image argmax scan and prediction stream
// Collects score words, then reads each image's 10 scores back through a 1-cycle RAM port.
module y_buf_argmax_sink #(
   parameter int IN_IMG_NUM       = 10,
   parameter int Y_BUF_DATA_WIDTH = 32,
   parameter int Y_BUF_DEPTH      = 10*IN_IMG_NUM*4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start_i,
   input  logic                            done_intr_i,
   input  logic                            y_buf_en,
   input  logic                            y_buf_wr_en,
   input  logic [$clog2(Y_BUF_DEPTH)-1:0]  y_buf_addr,
   input  logic [Y_BUF_DATA_WIDTH-1:0]     y_buf_data,
   output logic                            pred_valid_o,
   input  logic                            pred_ready_i,
   output logic [$clog2(IN_IMG_NUM)-1:0]   pred_img_o,
   output logic [3:0]                      pred_class_o,
   output logic [Y_BUF_DATA_WIDTH-1:0]     pred_score_o,
   output logic                            all_done_o,
   output logic                            err_o
);

   localparam int NW = 10*IN_IMG_NUM;
   localparam int AW = $clog2(Y_BUF_DEPTH);
   localparam int WW = $clog2(NW);
   localparam int IW = $clog2(IN_IMG_NUM);
   localparam int CW = $clog2(NW+1);
   localparam int DW = Y_BUF_DATA_WIDTH;
   localparam logic [DW-1:0] UNWRITTEN = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {S_COLLECT, S_SCAN, S_OUT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [NW-1:0]   written_q, written_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   img_q, img_d;
   logic [3:0]      rd_idx_q, rd_idx_d;
   logic            rd_vld_q, rd_vld_d;
   logic [3:0]      rd_cls_q, rd_cls_d;
   logic            rd_unw_q, rd_unw_d;
   logic [DW-1:0]   best_score_q, best_score_d;
   logic [3:0]      best_cls_q, best_cls_d;
   logic            pred_valid_q, pred_valid_d;
   logic            all_done_q, all_done_d;
   logic            err_q, err_d;

   logic [DW-1:0]   mem [NW];
   logic [DW-1:0]   mem_rd_q;

   logic [AW-3:0]   wr_word;
   logic [WW-1:0]   wr_idx;
   logic [WW-1:0]   rd_word;
   logic            wr_req;
   logic            wr_ok;
   logic [DW-1:0]   rd_score;

   assign wr_word  = y_buf_addr[AW-1:2];
   assign wr_idx   = WW'(wr_word);
   assign wr_req   = y_buf_en & y_buf_wr_en & ~start_i;
   assign wr_ok    = wr_req && (state_q == S_COLLECT) && (y_buf_addr[1:0] == 2'b00)
                     && (32'(wr_word) < NW);
   assign rd_word  = WW'(img_q) * WW'(10) + WW'(rd_idx_q);
   // Words never written this run must lose to any real score.
   assign rd_score = rd_unw_q ? UNWRITTEN : mem_rd_q;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_idx] <= y_buf_data;
      end
      mem_rd_q <= mem[rd_word];
   end

   always_comb begin
      state_d      = state_q;
      written_d    = written_q;
      cnt_d        = cnt_q;
      img_d        = img_q;
      rd_idx_d     = rd_idx_q;
      rd_vld_d     = 1'b0;
      rd_cls_d     = rd_idx_q;
      rd_unw_d     = ~written_q[rd_word];
      best_score_d = best_score_q;
      best_cls_d   = best_cls_q;
      pred_valid_d = pred_valid_q;
      all_done_d   = all_done_q;
      err_d        = err_q;

      if (start_i) begin
         state_d      = S_COLLECT;
         written_d    = '0;
         cnt_d        = '0;
         img_d        = '0;
         rd_idx_d     = '0;
         best_score_d = '0;
         best_cls_d   = '0;
         pred_valid_d = 1'b0;
         all_done_d   = 1'b0;
         err_d        = 1'b0;
      end else begin
         if (wr_req && !wr_ok) begin
            err_d = 1'b1;
         end
         if (wr_ok) begin
            written_d[wr_idx] = 1'b1;
            if (!written_q[wr_idx]) begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         case (state_q)
            S_COLLECT: begin
               if (cnt_d == CW'(NW) || done_intr_i) begin
                  state_d  = S_SCAN;
                  rd_idx_d = '0;
               end
            end
            S_SCAN: begin
               if (rd_idx_q < 4'd10) begin
                  rd_vld_d = 1'b1;
                  rd_idx_d = rd_idx_q + 4'd1;
               end
               // Class 0 seeds the running max; strict '>' keeps the lowest class on ties.
               if (rd_vld_q) begin
                  if (rd_cls_q == 4'd0 || $signed(rd_score) > $signed(best_score_q)) begin
                     best_score_d = rd_score;
                     best_cls_d   = rd_cls_q;
                  end
                  if (rd_cls_q == 4'd9) begin
                     state_d      = S_OUT;
                     pred_valid_d = 1'b1;
                  end
               end
            end
            S_OUT: begin
               if (pred_ready_i) begin
                  pred_valid_d = 1'b0;
                  if (img_q == IW'(IN_IMG_NUM-1)) begin
                     state_d    = S_DONE;
                     all_done_d = 1'b1;
                  end else begin
                     img_d    = img_q + IW'(1);
                     state_d  = S_SCAN;
                     rd_idx_d = '0;
                  end
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_COLLECT;
         written_q    <= '0;
         cnt_q        <= '0;
         img_q        <= '0;
         rd_idx_q     <= '0;
         rd_vld_q     <= 1'b0;
         rd_cls_q     <= '0;
         rd_unw_q     <= 1'b1;
         best_score_q <= '0;
         best_cls_q   <= '0;
         pred_valid_q <= 1'b0;
         all_done_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         written_q    <= written_d;
         cnt_q        <= cnt_d;
         img_q        <= img_d;
         rd_idx_q     <= rd_idx_d;
         rd_vld_q     <= rd_vld_d;
         rd_cls_q     <= rd_cls_d;
         rd_unw_q     <= rd_unw_d;
         best_score_q <= best_score_d;
         best_cls_q   <= best_cls_d;
         pred_valid_q <= pred_valid_d;
         all_done_q   <= all_done_d;
         err_q        <= err_d;
      end
   end

   assign pred_valid_o = pred_valid_q;
   assign pred_img_o   = img_q;
   assign pred_class_o = best_cls_q;
   assign pred_score_o = best_score_q;
   assign all_done_o   = all_done_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_y_buf_argmax_sink.sv
// tb/tb_y_buf_argmax_sink.sv - randomized directed bench for y_buf_argmax_sink
// Reference model keeps a word array plus written flags and computes argmax per image directly.
module tb_y_buf_argmax_sink;

   localparam int NW = 100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic        done_intr_i;
   logic        y_buf_en;
   logic        y_buf_wr_en;
   logic [8:0]  y_buf_addr;
   logic [31:0] y_buf_data;
   logic        pred_valid_o;
   logic        pred_ready_i;
   logic [3:0]  pred_img_o;
   logic [3:0]  pred_class_o;
   logic [31:0] pred_score_o;
   logic        all_done_o;
   logic        err_o;

   always #5 clk = ~clk;

   y_buf_argmax_sink dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .done_intr_i  (done_intr_i),
      .y_buf_en     (y_buf_en),
      .y_buf_wr_en  (y_buf_wr_en),
      .y_buf_addr   (y_buf_addr),
      .y_buf_data   (y_buf_data),
      .pred_valid_o (pred_valid_o),
      .pred_ready_i (pred_ready_i),
      .pred_img_o   (pred_img_o),
      .pred_class_o (pred_class_o),
      .pred_score_o (pred_score_o),
      .all_done_o   (all_done_o),
      .err_o        (err_o)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] m_mem [NW];
   bit          m_wr  [NW];
   int          m_cnt;
   bit          m_collect;
   bit          m_err;
   int          order [NW];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sc(input int w);
      return m_wr[w] ? m_mem[w] : 32'h8000_0000;
   endfunction

   task automatic ref_pred(input int img, output logic [3:0] c, output logic [31:0] s);
      s = sc(img*10);
      c = 4'd0;
      for (int k = 1; k < 10; k++) begin
         if ($signed(sc(img*10+k)) > $signed(s)) begin
            s = sc(img*10+k);
            c = 4'(k);
         end
      end
   endtask

   task automatic model_clear();
      m_collect = 1'b1;
      m_cnt     = 0;
      m_err     = 1'b0;
      for (int i = 0; i < NW; i++) m_wr[i] = 1'b0;
   endtask

   task automatic wr(input logic [8:0] a, input logic [31:0] d, input bit dn);
      int w;
      w = int'(a >> 2);
      y_buf_en    = 1'b1;
      y_buf_wr_en = 1'b1;
      y_buf_addr  = a;
      y_buf_data  = d;
      done_intr_i = dn;
      @(negedge clk);
      y_buf_en    = 1'b0;
      y_buf_wr_en = 1'b0;
      done_intr_i = 1'b0;
      if (m_collect && a[1:0] == 2'b00 && w < NW) begin
         if (!m_wr[w]) m_cnt++;
         m_wr[w]  = 1'b1;
         m_mem[w] = d;
         if (m_cnt == NW) m_collect = 1'b0;
      end else begin
         m_err = 1'b1;
      end
      if (dn) m_collect = 1'b0;
   endtask

   task automatic do_start(input bit with_wr);
      start_i = 1'b1;
      if (with_wr) begin
         y_buf_en    = 1'b1;
         y_buf_wr_en = 1'b1;
         y_buf_addr  = 9'd0;
         y_buf_data  = $urandom;
      end
      @(negedge clk);
      start_i     = 1'b0;
      y_buf_en    = 1'b0;
      y_buf_wr_en = 1'b0;
      model_clear();
   endtask

   task automatic shuffle();
      int j;
      int t;
      for (int i = 0; i < NW; i++) order[i] = i;
      for (int i = NW-1; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = order[i];
         order[i] = order[j];
         order[j] = t;
      end
   endtask

   task automatic write_all_shuffled();
      shuffle();
      for (int i = 0; i < NW; i++) begin
         wr(9'(order[i]*4), $urandom, 1'b0);
         if (i < NW-1 && $urandom_range(3, 0) == 0)
            wr(9'(order[$urandom_range(i, 0)]*4), $urandom, 1'b0);
      end
   endtask

   task automatic run_preds(input int first_lat, input int stall_img, input int abort_img);
      logic [3:0]  ec;
      logic [31:0] es;
      int n;
      int lat;
      lat = first_lat;
      for (int k = 0; k < 10; k++) begin
         n = 0;
         while (pred_valid_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("pred_latency", 64'(n), 64'(lat));
         ref_pred(k, ec, es);
         chk("pred_img", 64'(pred_img_o), 64'(k));
         chk("pred_class", 64'(pred_class_o), 64'(ec));
         chk("pred_score", 64'(pred_score_o), 64'(es));
         if (k == abort_img) return;
         if (k == stall_img) begin
            for (int s = 0; s < 20; s++) begin
               @(negedge clk);
               chk("stall_valid", 64'(pred_valid_o), 64'(1));
               chk("stall_img", 64'(pred_img_o), 64'(k));
               chk("stall_class", 64'(pred_class_o), 64'(ec));
               chk("stall_score", 64'(pred_score_o), 64'(es));
            end
         end
         pred_ready_i = 1'b1;
         @(negedge clk);
         pred_ready_i = 1'b0;
         chk("valid_drop", 64'(pred_valid_o), 64'(0));
         lat = 11;
      end
      chk("all_done", 64'(all_done_o), 64'(1));
      chk("err_end", 64'(err_o), 64'(m_err));
   endtask

   initial begin
      int d;
      rst_n        = 1'b0;
      start_i      = 1'b0;
      done_intr_i  = 1'b0;
      y_buf_en     = 1'b0;
      y_buf_wr_en  = 1'b0;
      y_buf_addr   = '0;
      y_buf_data   = '0;
      pred_ready_i = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(pred_valid_o), 64'(0));
      chk("rst_all_done", 64'(all_done_o), 64'(0));
      chk("rst_err", 64'(err_o), 64'(0));
      chk("rst_img", 64'(pred_img_o), 64'(0));
      chk("rst_class", 64'(pred_class_o), 64'(0));
      chk("rst_score", 64'(pred_score_o), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // ordered writes, image k peaks at class k
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < 10; c++) begin
            d = int'($urandom_range(2000, 0)) - 1000;
            if (c == k) d = 5000 + int'($urandom_range(1000, 0));
            wr(9'((k*10+c)*4), 32'(d), 1'b0);
         end
      end
      run_preds(11, -1, -1);
      repeat (3) @(negedge clk);
      chk("done_hold", 64'(all_done_o), 64'(1));
      chk("done_valid", 64'(pred_valid_o), 64'(0));

      // shuffled order with rewrites, consumer stalls on image 2
      do_start(1'b0);
      chk("start_all_done", 64'(all_done_o), 64'(0));
      write_all_shuffled();
      run_preds(11, 2, -1);

      // bad addresses, then ties and all-negative scores
      do_start(1'b0);
      wr(9'h006, $urandom, 1'b0);
      wr(9'd400, $urandom, 1'b0);
      chk("bad_addr_err", 64'(err_o), 64'(1));
      for (int w = 0; w < NW; w++) begin
         if (w < 10)       d = (w == 3 || w == 7) ? 9 : 5;
         else if (w < 20)  d = (w == 18) ? -1 : -2 - int'($urandom_range(1000, 0));
         else              d = int'($urandom);
         wr(9'(w*4), 32'(d), 1'b0);
      end
      run_preds(11, -1, -1);

      // partial collection forced out by done_intr_i
      do_start(1'b0);
      chk("partial_err0", 64'(err_o), 64'(0));
      shuffle();
      for (int i = 0; i < 50; i++) wr(9'(order[i]*4), $urandom, 1'b0);
      y_buf_en   = 1'b1;
      y_buf_addr = 9'(order[98]*4);
      y_buf_data = $urandom;
      @(negedge clk);
      y_buf_en = 1'b0;
      chk("en_only_err", 64'(err_o), 64'(0));
      wr(9'(order[50]*4), $urandom, 1'b1);
      wr(9'(order[99]*4), $urandom, 1'b0);
      run_preds(10, -1, -1);

      // restart in the middle of image 4's output
      do_start(1'b0);
      wr(9'h006, $urandom, 1'b0);
      write_all_shuffled();
      run_preds(11, -1, 4);
      do_start(1'b1);
      chk("abort_valid", 64'(pred_valid_o), 64'(0));
      chk("abort_err", 64'(err_o), 64'(0));
      chk("abort_all_done", 64'(all_done_o), 64'(0));
      chk("abort_img", 64'(pred_img_o), 64'(0));
      repeat (15) begin
         @(negedge clk);
         chk("abort_idle", 64'(pred_valid_o), 64'(0));
      end
      write_all_shuffled();
      run_preds(11, -1, -1);

      for (int r = 0; r < 2; r++) begin
         do_start(1'b0);
         write_all_shuffled();
         run_preds(11, int'($urandom_range(9, 0)), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
